// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: redirect, stall, interrupt and config-register signals.
// master = pipeline/requester side (drives requests, reads pc/flush/int_ack/cfg_rdata).
// slave  = pc_fetch_ctrl side (consumes requests, produces fetch address and pulses).
interface pc_fetch_ctrl_if;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        eret;
    logic [5:0]  hw_int;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic [31:0] pc;
    logic        flush;
    logic        int_ack;

    modport master (
        output stall, br_valid, br_target, eret, hw_int,
        output cfg_we, cfg_sel, cfg_wdata,
        input  cfg_rdata, pc, flush, int_ack
    );

    modport slave (
        input  stall, br_valid, br_target, eret, hw_int,
        input  cfg_we, cfg_sel, cfg_wdata,
        output cfg_rdata, pc, flush, int_ack
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer with interrupt entry, eret, branch redirect and SR/EPC/CAUSE registers.
// Latency: pc/flush/int_ack registered, 1 edge per decision; hw_int to entry is 2 edges.
// Backpressure: stall holds pc and drops br_valid (requester re-presents); stall never blocks entry.
// Ports: clk, reset (async active-low), bus (pc_fetch_ctrl_if.slave).
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic           clk,
    input  logic           reset,
    pc_fetch_ctrl_if.slave bus
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [5:0]  sr_im;
    logic        sr_exl, sr_ie;
    logic [29:0] epc_q;
    logic [5:0]  ip_q;
    logic        flush_q, int_ack_q;
    logic        flush_nxt, int_ack_nxt;

    logic pending;
    logic take_int, take_eret, take_br, take_seq;
    logic sr_wr, epc_wr;

    // Pending uses the registered IP copy, giving the fixed 2-edge entry latency.
    assign pending = (|(ip_q & sr_im)) & sr_ie & ~sr_exl;

    // Priority decode, only active in RUN; FLUSH ignores every request.
    assign take_int  = (state == RUN) && pending;
    assign take_eret = (state == RUN) && !pending && bus.eret && sr_exl;
    assign take_br   = (state == RUN) && !pending && !(bus.eret && sr_exl)
                       && !bus.stall && bus.br_valid;
    assign take_seq  = (state == RUN) && !pending && !(bus.eret && sr_exl)
                       && !bus.stall && !bus.br_valid;

    assign sr_wr  = bus.cfg_we && (bus.cfg_sel == 2'd0);
    assign epc_wr = bus.cfg_we && (bus.cfg_sel == 2'd1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    // Next-state logic: FLUSH lasts exactly one cycle.
    always_comb begin
        state_nxt = RUN;
        if (state == RUN && (take_int || take_eret))
            state_nxt = FLUSH;
    end

    // Output/datapath decode
    always_comb begin
        pc_nxt      = pc_q;
        flush_nxt   = 1'b0;
        int_ack_nxt = 1'b0;
        if (take_int) begin
            pc_nxt      = HANDLER_PC;
            flush_nxt   = 1'b1;
            int_ack_nxt = 1'b1;
        end else if (take_eret) begin
            pc_nxt    = {epc_q, 2'b00};
            flush_nxt = 1'b1;
        end else if (take_br) begin
            pc_nxt = {bus.br_target[31:2], 2'b00};
        end else if (take_seq) begin
            pc_nxt = pc_q + 32'd4;
        end
    end

    // Datapath registers; a hardware EXL/EPC update overrides a same-cycle software write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            epc_q     <= '0;
            ip_q      <= '0;
            flush_q   <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            pc_q      <= pc_nxt;
            ip_q      <= bus.hw_int;
            flush_q   <= flush_nxt;
            int_ack_q <= int_ack_nxt;
            if (sr_wr) begin
                sr_im <= bus.cfg_wdata[15:10];
                sr_ie <= bus.cfg_wdata[0];
            end
            if (take_int)       sr_exl <= 1'b1;
            else if (take_eret) sr_exl <= 1'b0;
            else if (sr_wr)     sr_exl <= bus.cfg_wdata[1];
            if (take_int)       epc_q <= pc_q[31:2];
            else if (epc_wr)    epc_q <= bus.cfg_wdata[31:2];
        end
    end

    // Combinational register read
    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_sel)
            2'd0:    bus.cfg_rdata = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
            2'd1:    bus.cfg_rdata = {epc_q, 2'b00};
            2'd2:    bus.cfg_rdata = {16'h0, ip_q, 10'h0};
            default: bus.cfg_rdata = '0;
        endcase
    end

    assign bus.pc      = pc_q;
    assign bus.flush   = flush_q;
    assign bus.int_ack = int_ack_q;

    logic unused_bits;
    assign unused_bits = ^{bus.cfg_wdata[31:16], bus.cfg_wdata[9:2], bus.br_target[1:0]};

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        flush;
        logic        ack;
    } exp_t;

    exp_t expq[$];

    pc_fetch_ctrl_if bus();

    pc_fetch_ctrl #(
        .RESET_PC  (32'h0000_3000),
        .HANDLER_PC(32'h0000_4180)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        bus.cfg_sel = sel;
        #1;
        chk(tag, bus.cfg_rdata, exp);
    endtask

    // Push the expectation for the coming edge, advance, then pop and compare.
    task automatic cyc(input string tag, input logic [31:0] pc, input logic f, input logic a);
        exp_t e;
        e.tag = tag; e.pc = pc; e.flush = f; e.ack = a;
        expq.push_back(e);
        @(posedge clk);
        #1;
        e = expq.pop_front();
        chk({e.tag, ".pc"}, bus.pc, e.pc);
        chk({e.tag, ".flush"}, {31'h0, bus.flush}, {31'h0, e.flush});
        chk({e.tag, ".ack"}, {31'h0, bus.int_ack}, {31'h0, e.ack});
    endtask

    initial begin
        bus.stall = 0; bus.br_valid = 0; bus.br_target = 0; bus.eret = 0;
        bus.hw_int = 0; bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_wdata = 0;

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("rst.pc", bus.pc, 32'h3000);
        chk("rst.flush", {31'h0, bus.flush}, 32'h0);
        chk("rst.ack", {31'h0, bus.int_ack}, 32'h0);
        rd("rst.sr", 2'd0, 32'h0);
        rd("rst.epc", 2'd1, 32'h0);
        rd("rst.cause", 2'd2, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Sequential fetch
        cyc("seq0", 32'h3004, 0, 0);
        cyc("seq1", 32'h3008, 0, 0);

        // SR write: IM bit 10, IE
        bus.cfg_we = 1; bus.cfg_sel = 0; bus.cfg_wdata = 32'hFFFF_0401;
        cyc("srwr", 32'h300C, 0, 0);
        bus.cfg_we = 0;
        rd("sr.after_wr", 2'd0, 32'h0000_0401);
        cyc("seq2", 32'h3010, 0, 0);

        // Interrupt raised while pc=0x3010
        bus.hw_int = 6'b000001;
        cyc("int.e1", 32'h3014, 0, 0);
        rd("int.cause", 2'd2, 32'h0000_0400);
        cyc("int.e2", 32'h4180, 1, 1);
        rd("int.epc", 2'd1, 32'h3014);
        rd("int.sr", 2'd0, 32'h0000_0403);
        cyc("int.flush", 32'h4180, 0, 0);
        cyc("int.run0", 32'h4184, 0, 0);
        cyc("int.noreent", 32'h4188, 0, 0);

        // eret, then the still-high interrupt is re-taken after FLUSH
        bus.eret = 1;
        cyc("eret", 32'h3014, 1, 0);
        bus.eret = 0;
        rd("eret.sr", 2'd0, 32'h0000_0401);
        cyc("eret.flush", 32'h3014, 0, 0);
        cyc("reint", 32'h4180, 1, 1);
        rd("reint.epc", 2'd1, 32'h3014);
        bus.hw_int = 0;
        cyc("reint.flush", 32'h4180, 0, 0);
        cyc("reint.run", 32'h4184, 0, 0);
        bus.eret = 1;
        cyc("eret2", 32'h3014, 1, 0);
        cyc("eret2.flush", 32'h3014, 0, 0);

        // eret with EXL=0 is a no-op
        cyc("eret.noexl", 32'h3018, 0, 0);
        bus.eret = 0;

        // Stall drops a simultaneous branch; branch taken once stall clears
        bus.stall = 1; bus.br_valid = 1; bus.br_target = 32'h3101;
        cyc("stall.hold", 32'h3018, 0, 0);
        bus.stall = 0;
        cyc("br", 32'h3100, 0, 0);
        bus.br_valid = 0;
        cyc("br.seq", 32'h3104, 0, 0);

        // Stall does not block interrupt entry; SR write racing entry keeps EXL=1
        bus.stall = 1; bus.hw_int = 6'b000001;
        cyc("stint.e1", 32'h3104, 0, 0);
        bus.cfg_we = 1; bus.cfg_sel = 0; bus.cfg_wdata = 32'h0000_0401;
        cyc("stint.e2", 32'h4180, 1, 1);
        bus.cfg_we = 0; bus.stall = 0; bus.hw_int = 0;
        rd("stint.sr", 2'd0, 32'h0000_0403);
        rd("stint.epc", 2'd1, 32'h3104);
        cyc("stint.flush", 32'h4180, 0, 0);

        // EPC software write masks low bits; CAUSE is read-only; sel 3 reads 0
        bus.cfg_we = 1; bus.cfg_sel = 1; bus.cfg_wdata = 32'h0000_5003;
        cyc("epcwr", 32'h4184, 0, 0);
        bus.cfg_we = 0;
        rd("epcwr.rd", 2'd1, 32'h5000);
        bus.cfg_we = 1; bus.cfg_sel = 2; bus.cfg_wdata = 32'hFFFF_FFFF;
        cyc("causewr", 32'h4188, 0, 0);
        bus.cfg_we = 0;
        rd("cause.ro", 2'd2, 32'h0);
        rd("sel3", 2'd3, 32'h0);
        rd("sr.keep", 2'd0, 32'h0000_0403);
        bus.eret = 1;
        cyc("eret3", 32'h5000, 1, 0);
        bus.eret = 0;
        cyc("eret3.flush", 32'h5000, 0, 0);

        // Wrap at top of address space
        bus.br_valid = 1; bus.br_target = 32'hFFFF_FFFF;
        cyc("br.top", 32'hFFFF_FFFC, 0, 0);
        bus.br_valid = 0;
        cyc("wrap", 32'h0000_0000, 0, 0);

        // Reset asserted mid-FLUSH
        bus.hw_int = 6'b000001;
        cyc("rint.e1", 32'h0000_0004, 0, 0);
        cyc("rint.e2", 32'h4180, 1, 1);
        #3 reset = 1'b0;
        #1;
        chk("arst.pc", bus.pc, 32'h3000);
        chk("arst.flush", {31'h0, bus.flush}, 32'h0);
        chk("arst.ack", {31'h0, bus.int_ack}, 32'h0);
        rd("arst.sr", 2'd0, 32'h0);
        rd("arst.epc", 2'd1, 32'h0);
        bus.hw_int = 0;
        @(posedge clk); #1;
        chk("arst.hold", bus.pc, 32'h3000);
        reset = 1'b1;
        cyc("post.rst", 32'h3004, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
